// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester byte streams and UART transmitter handshake of uart_tx_arbiter
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*DATA_BITS-1:0] req_data;
    logic [NUM_REQ-1:0]           req_last;
    logic [NUM_REQ-1:0]           req_ready;
    logic [DATA_BITS-1:0]         tx_data;
    logic                         tx_start;
    logic                         tx_busy;
    logic [GW-1:0]                grant_id;
    logic                         active;

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_data, tx_start, grant_id, active
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_data, tx_start, grant_id, active
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, packet-locked sharing of one UART transmitter
// Define UART_ARB_HEADER_EN to prefix each packet with a {1, grant_id} header byte.
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_BITS  = 8,
    parameter int GAP_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int GW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
`ifdef UART_ARB_HEADER_EN
    localparam logic [DATA_BITS-1:0] HDR_TOP = {1'b1, {(DATA_BITS-1){1'b0}}};
`endif

    typedef enum logic [2:0] {IDLE, HDR, SEND, WAIT_HI, WAIT_LO, GAP} state_t;

    state_t               state;
    logic [GW-1:0]        rr_ptr;
    logic [GW-1:0]        next_ptr;
    logic [GW-1:0]        win_hi;
    logic [GW-1:0]        win_lo;
    logic                 found_hi;
    logic                 found_lo;
    logic                 last;
    logic [1:0]           hi_cnt;
    logic [GCW-1:0]       gap_cnt;
    logic                 sel_valid;
    logic                 sel_last;
    logic [DATA_BITS-1:0] sel_data;
    logic [NUM_REQ-1:0]   sel_onehot;

    // Lowest valid index at or above rr_ptr wins; otherwise lowest valid index below it.
    always_comb begin
        win_hi   = '0;
        win_lo   = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                if (GW'(i) >= rr_ptr) begin
                    win_hi   = GW'(i);
                    found_hi = 1'b1;
                end else begin
                    win_lo   = GW'(i);
                    found_lo = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_valid  = 1'b0;
        sel_last   = 1'b0;
        sel_data   = '0;
        sel_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.grant_id == GW'(i)) begin
                sel_valid     = bus.req_valid[i];
                sel_last      = bus.req_last[i];
                sel_data      = bus.req_data[i*DATA_BITS +: DATA_BITS];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    assign next_ptr = (bus.grant_id == GW'(NUM_REQ - 1)) ? '0 : bus.grant_id + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            gap_cnt       <= '0;
            hi_cnt        <= '0;
            last          <= 1'b0;
            bus.req_ready <= '0;
            bus.tx_data   <= '0;
            bus.tx_start  <= 1'b0;
            bus.grant_id  <= '0;
            bus.active    <= 1'b0;
        end else begin
            bus.tx_start  <= 1'b0;
            bus.req_ready <= '0;
            case (state)
                IDLE: begin
                    if (found_hi || found_lo) begin
                        bus.grant_id <= found_hi ? win_hi : win_lo;
                        bus.active   <= 1'b1;
`ifdef UART_ARB_HEADER_EN
                        state        <= HDR;
`else
                        state        <= SEND;
`endif
                    end
                end
`ifdef UART_ARB_HEADER_EN
                HDR: begin
                    if (!bus.tx_busy) begin
                        bus.tx_start <= 1'b1;
                        bus.tx_data  <= HDR_TOP | DATA_BITS'(bus.grant_id);
                        last         <= 1'b0;
                        hi_cnt       <= '0;
                        state        <= WAIT_HI;
                    end
                end
`endif
                // Grant is held even while the owner's valid is low mid-packet.
                SEND: begin
                    if (!bus.tx_busy && sel_valid) begin
                        bus.tx_start  <= 1'b1;
                        bus.tx_data   <= sel_data;
                        bus.req_ready <= sel_onehot;
                        last          <= sel_last;
                        hi_cnt        <= '0;
                        state         <= WAIT_HI;
                    end
                end
                // A transmitter that never raises busy is treated as having finished the byte.
                WAIT_HI: begin
                    if (bus.tx_busy) begin
                        state <= WAIT_LO;
                    end else if (hi_cnt == 2'd3) begin
                        if (last) begin
                            state   <= GAP;
                            rr_ptr  <= next_ptr;
                            gap_cnt <= '0;
                        end else begin
                            state <= SEND;
                        end
                    end else begin
                        hi_cnt <= hi_cnt + 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (!bus.tx_busy) begin
                        if (last) begin
                            state   <= GAP;
                            rr_ptr  <= next_ptr;
                            gap_cnt <= '0;
                        end else begin
                            state <= SEND;
                        end
                    end
                end
                // Occupies GAP_CYCLES cycles; 0 and 1 both leave after a single cycle.
                GAP: begin
                    if (int'(gap_cnt) >= GAP_CYCLES - 1) begin
                        state      <= IDLE;
                        bus.active <= 1'b0;
                        gap_cnt    <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among NUM_REQ byte-stream requesters using round-robin arbitration with packet locking.
- Each requester presents bytes with valid/ready and marks its final byte with req_last.
- Holds a grant from first byte to last byte, then inserts a programmable idle gap before re-arbitrating.
- Sits between producer blocks and the UART TX datapath. Drives its tx_data/tx_start and observes its tx_busy.

Parameters:
- NUM_REQ, 4, number of requesters, 1..16.
- DATA_BITS, 8, byte width; must match the transmitter.
- GAP_CYCLES, 16, clk cycles of forced idle after each packet; 0 = no gap.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester byte valid.
- req_data  input  NUM_REQ*DATA_BITS  requester i occupies bits [i*DATA_BITS +: DATA_BITS].
- req_last  input  NUM_REQ  qualifies req_data as the final byte of a packet.
- req_ready  output  NUM_REQ  one-cycle byte-accept pulse, at most one bit set.
- tx_data  output  DATA_BITS  byte to transmitter, stable from tx_start until tx_busy falls.
- tx_start  output  1  one-cycle start pulse to transmitter.
- tx_busy  input  1  transmitter busy; rises 1..2 cycles after tx_start, falls when stop bit ends.
- grant_id  output  max(1,$clog2(NUM_REQ))  index of the current owner.
- active  output  1  high from grant until the gap expires.

Behaviour:
- Reset: state IDLE; all outputs 0; RR pointer 0; gap counter 0. Reset mid-byte abandons the byte; tx_start stays 0 and no req_ready is issued.
- IDLE:
  - If no req_valid bit is set, stay in IDLE.
  - Otherwise, scan from the RR pointer upward with wrap-around; the first valid index wins.
  - Latch the winner into grant_id, set active=1, go to SEND.
- SEND:
  - Go to WAIT_HI when tx_busy=0 and req_valid[grant_id]=1. In that same cycle: tx_start=1, tx_data=req_data[grant_id], req_ready[grant_id]=1, and latch last=req_last[grant_id].
  - Otherwise stay in SEND with the grant held. A requester dropping valid mid-packet does not lose the grant, and other requesters are ignored.
- WAIT_HI: wait for tx_busy=1, then go to WAIT_LO. If tx_busy is not seen within 4 cycles, treat the byte as done (protects against a missing transmitter).
- WAIT_LO:
  - On tx_busy=0: if last is set, go to GAP; otherwise go to SEND.
  - On exit to GAP, set the RR pointer to (grant_id+1) mod NUM_REQ.
- GAP:
  - Count GAP_CYCLES cycles, then go to IDLE with active=0.
  - If GAP_CYCLES=0, go to IDLE the next cycle.
- Single-byte packet (valid and last together on the first byte) is legal.
- No byte is issued during GAP.
- Requester contract: req_data/req_last must stay stable while req_valid is high and until ready.
- Fairness: with all requesters continuously valid, grants cycle 0,1,2,3,0…

Optional Feature:
- Macro: UART_ARB_HEADER_EN.
- Defined:
  - After arbitration, the first byte sent is the header {zero-padded grant_id} with the top bit set: 8'h80|grant_id for DATA_BITS=8.
  - Extra state HDR issues tx_start without any req_ready, passes through WAIT_HI/WAIT_LO, then goes to SEND. Payload bytes follow.
  - A reset in HDR behaves like any other reset.
- Undefined: no header; IDLE goes directly to SEND.

Test Plan:
- Single requester 0 sends 3 bytes 0x11,0x22,0x33 (last on 0x33), modelled tx_busy 10 cycles per byte → three tx_start pulses carrying those values; req_ready[0] pulses 3 times; active falls GAP_CYCLES=16 cycles after the final tx_busy fall.
- All 4 requesters valid with 1-byte packets 0xA0..0xA3 → order on tx_data is A0,A1,A2,A3,A0; grant_id follows 0,1,2,3.
- Requester 2 sends 0x55 without last, drops valid for 20 cycles while requester 1 is valid, then sends 0x66 with last → grant_id stays 2 throughout; requester 1 is granted only after the gap.
- Assert reset while in WAIT_LO → next cycle all outputs 0; after release, requester 3 valid gets grant_id=3 (pointer reset to 0, scan finds 3).
- Hold tx_busy low permanently, single byte 0x7E → WAIT_HI times out after 4 cycles, then GAP, then IDLE; no hang.
- With UART_ARB_HEADER_EN, requester 1 sends 0x42 with last → tx_data sequence 0x81, 0x42; req_ready[1] pulses only with 0x42.
